// File: rtl/pong_engine.sv
// Pong object engine: ball FSM, paddle motion and per-pixel object rendering.
// All game state advances once per frame on the tick pixel; drawing is combinational.
module pong_engine #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned TICK_Y     = 481,
  parameter int unsigned WALL_T_B   = 71,
  parameter int unsigned WALL_B_T   = 472,
  parameter int unsigned PAD_HEIGHT = 72,
  parameter int unsigned PAD_W      = 4,
  parameter int unsigned L_PAD_X    = 36,
  parameter int unsigned R_PAD_X    = 600,
  parameter int unsigned PAD_VEL    = 9,
  parameter int unsigned BALL_SIZE  = 8,
  parameter int unsigned BALL_SPEED = 6,
  parameter logic [11:0] FG_RGB     = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn,
  input  logic        gra_still,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        graph_on,
  output logic [1:0]  hit,
  output logic [1:0]  miss,
  output logic [11:0] graph_rgb
);

  localparam int unsigned BALL_X0    = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int unsigned BALL_Y0    = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int unsigned PAD_Y0     = (V_ACTIVE - PAD_HEIGHT) / 2;
  localparam int unsigned PAD_MAX    = WALL_B_T - PAD_HEIGHT;
  localparam int unsigned PAD_MIN    = WALL_T_B + 1;
  localparam int unsigned ZONE_H     = PAD_HEIGHT / 8;
  localparam int unsigned BALL_SHIFT = (BALL_SIZE == 16) ? 1 : 0;
  localparam int unsigned WALL_T_T   = 64;
  localparam int unsigned WALL_B_B   = V_ACTIVE - 1;
  localparam int unsigned R_EDGE     = H_ACTIVE - 1 - BALL_SPEED;
  localparam logic [9:0]  SPD_POS    = 10'(BALL_SPEED);
  localparam logic [9:0]  SPD_NEG    = 10'(1024 - BALL_SPEED);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OUT = 2'd2} state_t;

  state_t     state, state_nx;
  logic [2:0] serve_cnt, serve_cnt_nx;
  logic [9:0] ball_x, ball_x_nx, ball_y, ball_y_nx;
  logic [9:0] dx, dx_nx, dy, dy_nx;
  logic [9:0] l_pad_t, l_pad_nx, r_pad_t, r_pad_nx;
  logic [1:0] hit_nx, miss_nx;
  logic [9:0] dx_c, dy_c;
  logic signed [11:0] nxt_t;

  logic        tick;
  logic [10:0] ball_r, ball_b;
  logic        dx_neg, dx_pos, miss_l, miss_r, hit_l, hit_r;
  logic        l_row_ov, r_row_ov;
  logic [2:0]  zone_l, zone_r;

  function automatic logic [9:0] dy_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    dy_lut = 10'h3FD;
      3'd1:    dy_lut = 10'h3FE;
      3'd2,
      3'd3:    dy_lut = 10'h3FF;
      3'd4,
      3'd5:    dy_lut = 10'h001;
      3'd6:    dy_lut = 10'h002;
      default: dy_lut = 10'h003;
    endcase
  endfunction

  function automatic logic [2:0] zone_of(input logic [9:0] bt, input logic [9:0] pt);
    logic [11:0] diff;
    logic [11:0] q;
    diff = {2'b00, bt} + 12'(BALL_SIZE / 2) - {2'b00, pt};
    q    = diff / 12'(ZONE_H);
    if (diff[11])         zone_of = 3'd0;
    else if (q > 12'd7)   zone_of = 3'd7;
    else                  zone_of = q[2:0];
  endfunction

  // One frame of paddle motion, clamped against the inner wall faces.
  function automatic logic [9:0] pad_next(input logic [9:0] top, input logic up, input logic dn);
    logic [10:0] sum;
    sum = {1'b0, top} + 11'(PAD_VEL);
    if (dn && !up)
      pad_next = (sum > 11'(PAD_MAX)) ? 10'(PAD_MAX) : sum[9:0];
    else if (up && !dn)
      pad_next = (top < 10'(PAD_MIN + PAD_VEL)) ? 10'(PAD_MIN) : top - 10'(PAD_VEL);
    else
      pad_next = top;
  endfunction

  function automatic logic [7:0] ball_rom(input logic [2:0] row);
    case (row)
      3'd0, 3'd7: ball_rom = 8'h3C;
      3'd1, 3'd6: ball_rom = 8'h7E;
      default:    ball_rom = 8'hFF;
    endcase
  endfunction

  assign tick   = (y == 10'(TICK_Y)) && (x == 10'd0);
  assign ball_r = {1'b0, ball_x} + 11'(BALL_SIZE - 1);
  assign ball_b = {1'b0, ball_y} + 11'(BALL_SIZE - 1);
  assign dx_neg = dx[9];
  assign dx_pos = !dx[9] && (dx != 10'd0);

  assign miss_l   = dx_neg && (ball_x < 10'(BALL_SPEED));
  assign miss_r   = dx_pos && (ball_r > 11'(R_EDGE));
  assign l_row_ov = (ball_b >= {1'b0, l_pad_t}) &&
                    ({1'b0, ball_y} <= {1'b0, l_pad_t} + 11'(PAD_HEIGHT - 1));
  assign r_row_ov = (ball_b >= {1'b0, r_pad_t}) &&
                    ({1'b0, ball_y} <= {1'b0, r_pad_t} + 11'(PAD_HEIGHT - 1));
  assign hit_l    = dx_neg && l_row_ov && (ball_x <= 10'(L_PAD_X + PAD_W - 1)) &&
                    (ball_r >= 11'(L_PAD_X));
  assign hit_r    = dx_pos && r_row_ov && (ball_x <= 10'(R_PAD_X + PAD_W - 1)) &&
                    (ball_r >= 11'(R_PAD_X));
  assign zone_l   = zone_of(ball_y, l_pad_t);
  assign zone_r   = zone_of(ball_y, r_pad_t);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= 3'd0;
      ball_x    <= 10'(BALL_X0);
      ball_y    <= 10'(BALL_Y0);
      dx        <= SPD_POS;
      dy        <= 10'd1;
      l_pad_t   <= 10'(PAD_Y0);
      r_pad_t   <= 10'(PAD_Y0);
      hit       <= 2'b00;
      miss      <= 2'b00;
    end else begin
      state     <= state_nx;
      serve_cnt <= serve_cnt_nx;
      ball_x    <= ball_x_nx;
      ball_y    <= ball_y_nx;
      dx        <= dx_nx;
      dy        <= dy_nx;
      l_pad_t   <= l_pad_nx;
      r_pad_t   <= r_pad_nx;
      hit       <= hit_nx;
      miss      <= miss_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    serve_cnt_nx = serve_cnt;
    ball_x_nx    = ball_x;
    ball_y_nx    = ball_y;
    dx_nx        = dx;
    dy_nx        = dy;
    l_pad_nx     = l_pad_t;
    r_pad_nx     = r_pad_t;
    hit_nx       = 2'b00;
    miss_nx      = 2'b00;
    dx_c         = dx;
    dy_c         = dy;
    nxt_t        = 12'sd0;
    if (tick) begin
      l_pad_nx = pad_next(l_pad_t, btn[2], btn[3]);
      r_pad_nx = pad_next(r_pad_t, btn[0], btn[1]);
      if (gra_still) begin
        state_nx  = SERVE;
        ball_x_nx = 10'(BALL_X0);
        ball_y_nx = 10'(BALL_Y0);
        if (state == SERVE) serve_cnt_nx = serve_cnt + 3'd1;
      end else begin
        case (state)
          SERVE: begin
            state_nx     = PLAY;
            serve_cnt_nx = serve_cnt + 3'd1;
            ball_x_nx    = 10'(BALL_X0);
            ball_y_nx    = 10'(BALL_Y0);
            dx_nx        = serve_cnt[0] ? SPD_POS : SPD_NEG;
            dy_nx        = dy_lut(serve_cnt);
          end
          PLAY: begin
            if (miss_l) begin
              miss_nx  = 2'b01;
              state_nx = OUT;
            end else if (miss_r) begin
              miss_nx  = 2'b10;
              state_nx = OUT;
            end else begin
              if (hit_l) begin
                dx_c   = SPD_POS;
                dy_c   = dy_lut(zone_l);
                hit_nx = 2'b01;
              end else if (hit_r) begin
                dx_c   = SPD_NEG;
                dy_c   = dy_lut(zone_r);
                hit_nx = 2'b10;
              end
              // Bounce when this frame's step would carry the ball into a wall.
              nxt_t = $signed({2'b00, ball_y}) + $signed({{2{dy_c[9]}}, dy_c});
              if (dy_c[9] && (nxt_t <= $signed(12'(WALL_T_B))))
                dy_c = ~dy_c + 10'd1;
              else if (!dy_c[9] && (dy_c != 10'd0) &&
                       (nxt_t + $signed(12'(BALL_SIZE - 1)) >= $signed(12'(WALL_B_T))))
                dy_c = ~dy_c + 10'd1;
              dx_nx     = dx_c;
              dy_nx     = dy_c;
              ball_x_nx = ball_x + dx_c;
              ball_y_nx = ball_y + dy_c;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic       wall_on, l_pad_on, r_pad_on, ball_sq, ball_on;
  logic [2:0] rom_row, rom_col;
  logic [7:0] rom_bits;

  assign wall_on  = ((y >= 10'(WALL_T_T)) && (y <= 10'(WALL_T_B))) ||
                    ((y >= 10'(WALL_B_T)) && (y <= 10'(WALL_B_B)));
  assign l_pad_on = (x >= 10'(L_PAD_X)) && (x <= 10'(L_PAD_X + PAD_W - 1)) &&
                    (y >= l_pad_t) && ({1'b0, y} <= {1'b0, l_pad_t} + 11'(PAD_HEIGHT - 1));
  assign r_pad_on = (x >= 10'(R_PAD_X)) && (x <= 10'(R_PAD_X + PAD_W - 1)) &&
                    (y >= r_pad_t) && ({1'b0, y} <= {1'b0, r_pad_t} + 11'(PAD_HEIGHT - 1));
  assign ball_sq  = (x >= ball_x) && ({1'b0, x} <= ball_r) &&
                    (y >= ball_y) && ({1'b0, y} <= ball_b);
  // Large balls reuse the 8x8 ROM by dropping the low offset bit.
  assign rom_row  = 3'((y - ball_y) >> BALL_SHIFT);
  assign rom_col  = 3'((x - ball_x) >> BALL_SHIFT);
  assign rom_bits = ball_rom(rom_row);
  assign ball_on  = ball_sq && rom_bits[~rom_col];
  assign graph_on = wall_on || l_pad_on || r_pad_on || ball_on;

  always_comb begin
    graph_rgb = BG_RGB;
    if (wall_on)                    graph_rgb = FG_RGB;
    else if (l_pad_on || r_pad_on)  graph_rgb = FG_RGB;
    else if (ball_on)               graph_rgb = FG_RGB;
    if (!video_on)                  graph_rgb = 12'h000;
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: serve, paddles, walls, paddle hit, miss, reset and render.
module tb_pong_engine;

  localparam int ST_SERVE = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_OUT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic        gra_still;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        graph_on;
  logic [1:0]  hit;
  logic [1:0]  miss;
  logic [11:0] graph_rgb;

  int total = 0;
  int bad   = 0;

  pong_engine dut (
    .clk(clk), .reset(reset), .btn(btn), .gra_still(gra_still),
    .video_on(video_on), .x(x), .y(y), .graph_on(graph_on),
    .hit(hit), .miss(miss), .graph_rgb(graph_rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    x = 10'd0;
    y = 10'd481;
    @(posedge clk);
    #1;
    x = 10'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_ball(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(dut.ball_x), 32'(ex));
    check({tag, "_y"}, 32'(dut.ball_y), 32'(ey));
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic on);
    x = 10'(px);
    y = 10'(py);
    #1;
    check({tag, "_on"}, 32'(graph_on), 32'(on));
    check({tag, "_rgb"}, 32'(graph_rgb), on ? 32'hFFF : 32'h000);
    x = 10'd1;
    y = 10'd481;
  endtask

  initial begin
    int lmax;
    int lmin;
    reset = 1'b1; btn = 4'b0000; gra_still = 1'b0; video_on = 1'b1;
    x = 10'd1; y = 10'd0;
    do_reset();

    // reset state
    chk_ball("rst_ball", 316, 236);
    check("rst_dx", 32'(dut.dx), 32'd6);
    check("rst_dy", 32'(dut.dy), 32'd1);
    check("rst_lpad", 32'(dut.l_pad_t), 32'd204);
    check("rst_rpad", 32'(dut.r_pad_t), 32'd204);
    check("rst_state", 32'(dut.state), ST_SERVE);
    check("rst_cnt", 32'(dut.serve_cnt), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);

    // render: ball ROM corners, walls, paddle edges
    pix("ball_mid", 320, 240, 1'b1);
    pix("ball_c0", 316, 236, 1'b0);
    pix("ball_c2", 318, 236, 1'b1);
    pix("ball_r1c0", 316, 237, 1'b0);
    pix("ball_r2c0", 316, 238, 1'b1);
    pix("wall_t", 100, 71, 1'b1);
    pix("below_wall_t", 100, 72, 1'b0);
    pix("above_wall_t", 100, 63, 1'b0);
    pix("wall_b", 100, 472, 1'b1);
    pix("lpad_tl", 36, 204, 1'b1);
    pix("lpad_left", 35, 204, 1'b0);
    pix("rpad_br", 603, 275, 1'b1);
    pix("rpad_right", 604, 275, 1'b0);
    pix("rpad_below", 603, 276, 1'b0);

    // serve hold then release
    gra_still = 1'b1;
    ticks(3);
    check("srv_cnt", 32'(dut.serve_cnt), 32'd3);
    chk_ball("srv_ball", 316, 236);
    check("srv_lpad", 32'(dut.l_pad_t), 32'd204);
    check("srv_state", 32'(dut.state), ST_SERVE);
    gra_still = 1'b0;
    do_tick();
    check("rel_dx", 32'(dut.dx), 32'd6);
    check("rel_dy", 32'(dut.dy), 32'h3FF);
    check("rel_state", 32'(dut.state), ST_PLAY);
    do_tick();
    chk_ball("play1", 322, 235);

    // reset coinciding with a tick wins
    btn = 4'b1000;
    reset = 1'b1;
    x = 10'd0; y = 10'd481;
    @(posedge clk);
    #1;
    reset = 1'b0; x = 10'd1;
    btn = 4'b0000;
    chk_ball("rtk_ball", 316, 236);
    check("rtk_dx", 32'(dut.dx), 32'd6);
    check("rtk_dy", 32'(dut.dy), 32'd1);
    check("rtk_state", 32'(dut.state), ST_SERVE);
    check("rtk_lpad", 32'(dut.l_pad_t), 32'd204);
    check("rtk_hit", 32'(hit), 32'd0);
    check("rtk_miss", 32'(miss), 32'd0);

    // paddle clamps
    gra_still = 1'b1;
    btn = 4'b1000;
    lmax = 0;
    for (int i = 0; i < 40; i++) begin
      do_tick();
      if (int'(dut.l_pad_t) > lmax) lmax = int'(dut.l_pad_t);
    end
    check("lpad_down", 32'(dut.l_pad_t), 32'd400);
    check("lpad_max", 32'(lmax), 32'd400);
    check("rpad_idle", 32'(dut.r_pad_t), 32'd204);
    btn = 4'b0100;
    lmin = 1023;
    for (int i = 0; i < 40; i++) begin
      do_tick();
      if (int'(dut.l_pad_t) < lmin) lmin = int'(dut.l_pad_t);
    end
    check("lpad_up", 32'(dut.l_pad_t), 32'd72);
    check("lpad_min", 32'(lmin), 32'd72);
    btn = 4'b1100;
    ticks(3);
    check("lpad_both", 32'(dut.l_pad_t), 32'd72);
    btn = 4'b0011;
    ticks(3);
    check("rpad_both", 32'(dut.r_pad_t), 32'd204);
    btn = 4'b0010;
    ticks(2);
    check("rpad_down", 32'(dut.r_pad_t), 32'd222);
    btn = 4'b0000;
    gra_still = 1'b0;

    // zone-0 left hit, then top wall bounce at y=74
    do_reset();
    btn = 4'b0100;
    do_tick();
    check("w_rel_dx", 32'(dut.dx), 32'h3FA);
    check("w_rel_dy", 32'(dut.dy), 32'h3FD);
    ticks(11);
    btn = 4'b0000;
    ticks(36);
    check("w_lpad", 32'(dut.l_pad_t), 32'd96);
    chk_ball("w_pre_hit", 34, 95);
    do_tick();
    check("w_hit", 32'(hit), 32'd1);
    check("w_hit_dx", 32'(dut.dx), 32'd6);
    check("w_hit_dy", 32'(dut.dy), 32'h3FD);
    chk_ball("w_post_hit", 40, 92);
    @(posedge clk);
    #1;
    check("w_hit_clr", 32'(hit), 32'd0);
    ticks(6);
    chk_ball("w_at74", 76, 74);
    check("w_at74_dy", 32'(dut.dy), 32'h3FD);
    do_tick();
    check("w_bounce_dy", 32'(dut.dy), 32'd3);
    chk_ball("w_bounce", 82, 77);

    // zone-4 left hit
    do_reset();
    gra_still = 1'b1;
    btn = 4'b1000;
    ticks(4);
    gra_still = 1'b0;
    do_tick();
    btn = 4'b0000;
    check("z_rel_dx", 32'(dut.dx), 32'h3FA);
    check("z_rel_dy", 32'(dut.dy), 32'd1);
    check("z_lpad", 32'(dut.l_pad_t), 32'd249);
    ticks(47);
    chk_ball("z_pre_hit", 34, 283);
    do_tick();
    check("z_hit", 32'(hit), 32'd1);
    check("z_hit_dx", 32'(dut.dx), 32'd6);
    check("z_hit_dy", 32'(dut.dy), 32'd1);
    chk_ball("z_post_hit", 40, 284);
    @(posedge clk);
    #1;
    check("z_hit_clr", 32'(hit), 32'd0);
    check("z_miss_idle", 32'(miss), 32'd0);

    // left miss, frozen in OUT, recentre via gra_still
    do_reset();
    do_tick();
    ticks(52);
    chk_ball("m_pre", 4, 80);
    do_tick();
    check("m_miss", 32'(miss), 32'd1);
    check("m_hit", 32'(hit), 32'd0);
    check("m_state", 32'(dut.state), ST_OUT);
    chk_ball("m_frozen0", 4, 80);
    @(posedge clk);
    #1;
    check("m_miss_clr", 32'(miss), 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check("m_out_quiet", 32'(miss), 32'd0);
    end
    chk_ball("m_frozen5", 4, 80);
    check("m_out_dx", 32'(dut.dx), 32'h3FA);
    gra_still = 1'b1;
    do_tick();
    gra_still = 1'b0;
    check("m_serve", 32'(dut.state), ST_SERVE);
    chk_ball("m_recenter", 316, 236);

    // blanking keeps graph_on but zeroes colour
    video_on = 1'b0;
    x = 10'd320; y = 10'd240;
    #1;
    check("blank_on", 32'(graph_on), 32'd1);
    check("blank_rgb", 32'(graph_rgb), 32'h000);
    video_on = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
